// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - queued fixed-width pulse stretcher for indicator drive
//
// Turns rising edges of i_pulse into fixed-width high levels on o_level, one
// per event. Events that arrive while a level or its trailing gap is still in
// progress are counted and replayed back to back, GAP_CYCLES apart.
//
// Ports
//   clock       in   1           system clock, rising edge
//   reset       in   1           asynchronous, active-low reset
//   i_pulse     in   1           event input; only 0->1 transitions count
//   o_level     out  1           stretched output level (registered)
//   o_busy      out  1           high while a level or gap is in progress
//   o_pending   out  PEND_WIDTH  queued events not yet output
//   o_overflow  out  1           one-cycle pulse: event dropped, queue full
`timescale 1ns/1ps

module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int QUEUE_DEPTH = 3,
  parameter int PEND_WIDTH  = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_pulse,
  output logic                  o_level,
  output logic                  o_busy,
  output logic [PEND_WIDTH-1:0] o_pending,
  output logic                  o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  HIGH_LOAD = CNT_WIDTH'(HIGH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = PEND_WIDTH'(QUEUE_DEPTH);
  localparam logic [PEND_WIDTH-1:0] PEND_ONE  = PEND_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [PEND_WIDTH-1:0]   pend_q, pend_d;
  logic                    prev_q;
  logic                    level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic                    rise;

  // A held-high input is a single event; prev_q clears on reset so an input
  // that is already high when reset releases still counts once.
  assign rise = i_pulse & ~prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end

      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (rise) begin
          if (pend_q < PEND_MAX) pend_d = pend_q + PEND_ONE;
          else                   ovf_d  = 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          // End of gap: the dequeue frees a slot before a same-edge rise is
          // counted, so a full queue plus a rise here nets to no change.
          if (pend_q != '0) begin
            state_d = S_HIGH;
            cnt_d   = HIGH_LOAD;
            if (!rise) pend_d = pend_q - PEND_ONE;
          end else if (rise) begin
            // Skip the idle cycle: the new event starts immediately.
            state_d = S_HIGH;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (rise) begin
            if (pend_q < PEND_MAX) pend_d = pend_q + PEND_ONE;
            else                   ovf_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase
  end

  assign level_d = (state_d == S_HIGH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      prev_q  <= 1'b0;
      level_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      prev_q  <= i_pulse;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_level    = level_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_pending  = pend_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - self-checking bench for pulse_stretcher
`timescale 1ns/1ps

module tb_pulse_stretcher;

  localparam int H = 4;
  localparam int G = 2;
  localparam int Q = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       i_pulse = 1'b0;
  logic       o_level;
  logic       o_busy;
  logic [1:0] o_pending;
  logic       o_overflow;

  int errors = 0;
  int checks = 0;

  always #1 clock = ~clock;

  pulse_stretcher #(
    .HIGH_CYCLES(H),
    .GAP_CYCLES (G),
    .QUEUE_DEPTH(Q),
    .PEND_WIDTH (2),
    .CNT_WIDTH  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_pulse   (i_pulse),
    .o_level   (o_level),
    .o_busy    (o_busy),
    .o_pending (o_pending),
    .o_overflow(o_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Timeline model: each accepted event gets a start cycle. An event seen
  // while idle starts at once; otherwise it starts H+G after the previous
  // one. Pending = accepted events whose start lies in the future.
  int   cyc = 0;
  int   busy_end = 0;
  int   starts[$];
  bit   m_prev = 1'b0;
  int   lvl_total = 0;
  int   busy_total = 0;
  int   ovf_total = 0;

  always @(posedge clock) begin
    bit rise;
    bit drop;
    int npend;
    bit e_lvl;
    bit e_busy;
    int e_pend;
    cyc++;
    drop = 1'b0;
    if (!reset) begin
      starts.delete();
      m_prev   = 1'b0;
      busy_end = cyc;
    end else begin
      rise   = i_pulse && !m_prev;
      m_prev = i_pulse;
      if (rise) begin
        if (cyc >= busy_end) begin
          starts.push_back(cyc);
          busy_end = cyc + H + G;
        end else begin
          npend = 0;
          foreach (starts[i]) if (starts[i] > cyc) npend++;
          if (npend >= Q) drop = 1'b1;
          else begin
            starts.push_back(busy_end);
            busy_end = busy_end + H + G;
          end
        end
      end
    end
    while (starts.size() > 0 && starts[0] + H <= cyc) void'(starts.pop_front());
    e_lvl  = 1'b0;
    e_pend = 0;
    foreach (starts[i]) begin
      if (starts[i] <= cyc && cyc < starts[i] + H) e_lvl = 1'b1;
      if (starts[i] > cyc) e_pend++;
    end
    e_busy = reset && (cyc < busy_end);
    #0.5;
    check("level",    {31'd0, o_level},    {31'd0, e_lvl});
    check("busy",     {31'd0, o_busy},     {31'd0, e_busy});
    check("pending",  {30'd0, o_pending},  e_pend);
    check("overflow", {31'd0, o_overflow}, {31'd0, drop});
    lvl_total  += int'(o_level);
    busy_total += int'(o_busy);
    ovf_total  += int'(o_overflow);
  end

  task automatic drive(input logic v);
    @(negedge clock);
    i_pulse = v;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #0.6;
      n++;
    end while (o_busy && n < 300);
    if (o_busy) check(name, 32'd1, 32'd0);
  endtask

  initial begin
    int l0, b0, v0;
    // Test 1: reset held low, input low.
    repeat (4) @(negedge clock);
    check("rst_level",    {31'd0, o_level},    0);
    check("rst_busy",     {31'd0, o_busy},     0);
    check("rst_pending",  {30'd0, o_pending},  0);
    check("rst_overflow", {31'd0, o_overflow}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Test 2: one long high input -> one 4-cycle level, 6 busy cycles.
    l0 = lvl_total; b0 = busy_total;
    drive(1'b1);
    @(posedge clock); #0.6;
    check("t2_latency_level", {31'd0, o_level}, 1);
    repeat (40) @(negedge clock);
    i_pulse = 1'b0;
    wait_idle("t2_idle_timeout");
    check("t2_level_cycles", lvl_total - l0, 4);
    check("t2_busy_cycles",  busy_total - b0, 6);

    // Test 3: three short pulses -> pending reaches 2, three levels.
    l0 = lvl_total; b0 = busy_total;
    for (int i = 0; i < 5; i++) drive((i % 2) == 0);
    @(posedge clock); #0.6;
    check("t3_pending_peak", {30'd0, o_pending}, 2);
    drive(1'b0);
    wait_idle("t3_idle_timeout");
    check("t3_level_cycles", lvl_total - l0, 12);
    check("t3_busy_cycles",  busy_total - b0, 18);
    check("t3_pending_end",  {30'd0, o_pending}, 0);

    // Tests 4/5: toggling input saturates the queue, one drop, then a rise
    // exactly on a dequeue edge with the queue full.
    l0 = lvl_total; b0 = busy_total; v0 = ovf_total;
    for (int i = 0; i < 13; i++) drive((i % 2) == 0);
    @(posedge clock); #0.6;
    check("t5_pending_full",  {30'd0, o_pending},  3);
    check("t5_no_overflow",   {31'd0, o_overflow}, 0);
    check("t4_overflow_once", ovf_total - v0, 1);
    drive(1'b0);
    wait_idle("t4_idle_timeout");
    check("t4_level_cycles", lvl_total - l0, 24);
    check("t4_busy_cycles",  busy_total - b0, 36);
    check("t4_overflow_total", ovf_total - v0, 1);

    // Test 6: async reset mid-level with two queued, input left high.
    for (int i = 0; i < 8; i++) drive((i % 2) == 0 || i == 7);
    @(posedge clock); #0.6;
    check("t6_pre_pending", {30'd0, o_pending}, 2);
    check("t6_pre_level",   {31'd0, o_level},   1);
    #0.2 reset = 1'b0;
    #0.1;
    check("t6_async_level",   {31'd0, o_level},   0);
    check("t6_async_pending", {30'd0, o_pending}, 0);
    check("t6_async_busy",    {31'd0, o_busy},    0);
    repeat (2) @(negedge clock);
    l0 = lvl_total;
    reset = 1'b1;
    repeat (20) @(negedge clock);
    i_pulse = 1'b0;
    wait_idle("t6_idle_timeout");
    check("t6_level_cycles", lvl_total - l0, 4);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
